// File: rtl/fabric_cfg_pkg.sv
// Shared types and sizing helpers for the fabric mux-select configuration loader.
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck,
        StCommit
    } cfg_state_e;

    function automatic int unsigned total_bits(input int unsigned num_mux,
                                               input int unsigned swidth);
        return num_mux * swidth;
    endfunction

    // Counter must be able to hold TOTAL itself, hence TOTAL+1 codes.
    function automatic int unsigned cnt_width(input int unsigned total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/mux_sel_cfg_loader.sv
// Serial loader for MUXN select fields: shifts a bit stream into a shadow register,
// range-checks every field, then commits all selects atomically to sel_out_o.
module mux_sel_cfg_loader
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned IWIDTH  = 20,
    parameter int unsigned SWIDTH  = 5,
    parameter int unsigned NUM_MUX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_start_i,
    input  logic                        cfg_in_i,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    output logic                        cfg_out_o,
    output logic [NUM_MUX*SWIDTH-1:0]   sel_out_o,
    output logic                        cfg_done_o,
    output logic                        cfg_err_o
);

    localparam int unsigned Total = total_bits(NUM_MUX, SWIDTH);
    localparam int unsigned CntW  = cnt_width(Total);

    localparam logic [CntW-1:0]   LastCnt   = CntW'(Total - 1);
    localparam logic [CntW-1:0]   CntOne    = CntW'(1);
    // One extra bit so IWIDTH == 2**SWIDTH is representable; the compare then never fires.
    localparam logic [SWIDTH:0]   IwidthExt = (SWIDTH + 1)'(IWIDTH);

    cfg_state_e         state_q, state_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [Total-1:0]   shadow_q, shadow_d;
    logic [Total-1:0]   sel_q, sel_d;
    logic               cfg_out_q, cfg_out_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [NUM_MUX-1:0] field_bad;

    for (genvar k = 0; k < NUM_MUX; k++) begin : g_range
        assign field_bad[k] = {1'b0, shadow_q[k*SWIDTH +: SWIDTH]} >= IwidthExt;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shadow_d    = shadow_q;
        sel_d       = sel_q;
        cfg_out_d   = cfg_out_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cfg_ready_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_start_i) begin
                    state_d = StLoad;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                cfg_ready_o = 1'b1;
                // A restart wins over a simultaneous beat; the shadow is left as is.
                if (cfg_start_i) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (cfg_valid_i) begin
                    shadow_d  = {cfg_in_i, shadow_q[Total-1:1]};
                    cfg_out_d = shadow_q[0];
                    count_d   = count_q + CntOne;
                    if (count_q == LastCnt) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (|field_bad) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                sel_d   = shadow_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            shadow_q  <= '0;
            sel_q     <= '0;
            cfg_out_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            sel_q     <= sel_d;
            cfg_out_q <= cfg_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cfg_out_o  = cfg_out_q;
    assign sel_out_o  = sel_q;
    assign cfg_done_o = done_q;
    assign cfg_err_o  = err_q;

endmodule

// File: tb/tb_mux_sel_cfg_loader.sv
// Self-checking bench for mux_sel_cfg_loader with two 5-bit fields over 20 mux inputs.
module tb_mux_sel_cfg_loader;

    localparam int unsigned IW  = 20;
    localparam int unsigned SW  = 5;
    localparam int unsigned NM  = 2;
    localparam int unsigned TOT = NM * SW;

    typedef struct {
        logic [SW-1:0]  f0;
        logic [SW-1:0]  f1;
        bit             bub;
        logic [TOT-1:0] exp_sel;
        bit             exp_err;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_start_i = 1'b0;
    logic           cfg_in_i = 1'b0;
    logic           cfg_valid_i = 1'b0;
    logic           cfg_ready_o;
    logic           cfg_out_o;
    logic [TOT-1:0] sel_out_o;
    logic           cfg_done_o;
    logic           cfg_err_o;

    int             n_cmp = 0;
    int             n_bad = 0;
    bit             shadow_m[$];
    logic [TOT-1:0] sel_m;
    logic [31:0]    mux_data;
    logic [NM-1:0]  mux_y;

    always #5 clk = ~clk;

    mux_sel_cfg_loader #(
        .IWIDTH (IW),
        .SWIDTH (SW),
        .NUM_MUX(NM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start_i(cfg_start_i),
        .cfg_in_i   (cfg_in_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_out_o  (cfg_out_o),
        .sel_out_o  (sel_out_o),
        .cfg_done_o (cfg_done_o),
        .cfg_err_o  (cfg_err_o)
    );

    // Behavioural MUXN consumers driven by the committed selects.
    for (genvar k = 0; k < NM; k++) begin : g_mux
        assign mux_y[k] = mux_data[sel_out_o[k*SW +: SW]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        shadow_m.delete();
        for (int i = 0; i < TOT; i++) shadow_m.push_back(1'b0);
        sel_m = '0;
    endtask

    // Shadow modelled as a FIFO: oldest bit leaves first as cfg_out.
    task automatic model_beat(input bit b, output bit out);
        out = shadow_m.pop_front();
        shadow_m.push_back(b);
    endtask

    task automatic pulse_start();
        cfg_start_i = 1'b1;
        cfg_valid_i = 1'b1;
        cfg_in_i    = 1'b1;
        @(posedge clk); #1;
        cfg_start_i = 1'b0;
        cfg_valid_i = 1'b0;
        chk("ready_after_start", 32'(cfg_ready_o), 32'd1);
        chk("err_cleared_by_start", 32'(cfg_err_o), 32'd0);
    endtask

    task automatic send_bits(input logic [TOT-1:0] word, input int n, input bit bubbles);
        int guard;
        int i;
        bit v;
        bit e;
        guard = 0;
        i = 0;
        while (i < n && guard < 400) begin
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("ready_in_load", 32'(cfg_ready_o), 32'd1);
            cfg_valid_i = v;
            cfg_in_i    = word[i];
            @(posedge clk); #1;
            if (v) begin
                model_beat(word[i], e);
                chk("cfg_out", 32'(cfg_out_o), 32'(e));
                i++;
            end
            chk("sel_stable_mid_load", 32'(sel_out_o), 32'(sel_m));
            guard++;
        end
        cfg_valid_i = 1'b0;
        if (i < n) chk("beat_budget", i, n);
    endtask

    task automatic finish_load(input logic [TOT-1:0] exp_sel, input bit exp_err);
        @(posedge clk); #1;
        chk("ready_in_check", 32'(cfg_ready_o), 32'd0);
        chk("done_early", 32'(cfg_done_o), 32'd0);
        chk("sel_early", 32'(sel_out_o), 32'(sel_m));
        @(posedge clk); #1;
        sel_m = exp_sel;
        chk("done_pulse", 32'(cfg_done_o), 32'(!exp_err));
        chk("sel_commit", 32'(sel_out_o), 32'(exp_sel));
        chk("err_flag", 32'(cfg_err_o), 32'(exp_err));
        @(posedge clk); #1;
        chk("done_single", 32'(cfg_done_o), 32'd0);
        chk("err_sticky", 32'(cfg_err_o), 32'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           vecs[7];
        logic [TOT-1:0] w;
        logic [SW-1:0]  f0;
        logic [SW-1:0]  f1;
        bit             legal;

        vecs[0] = '{5'd3,  5'd17, 1'b0, 10'h223, 1'b0};
        vecs[1] = '{5'd3,  5'd25, 1'b0, 10'h223, 1'b1};
        vecs[2] = '{5'd3,  5'd17, 1'b1, 10'h223, 1'b0};
        vecs[3] = '{5'd19, 5'd0,  1'b1, 10'h013, 1'b0};
        vecs[4] = '{5'd31, 5'd31, 1'b0, 10'h013, 1'b1};
        vecs[5] = '{5'd0,  5'd19, 1'b1, 10'h260, 1'b0};
        vecs[6] = '{5'd20, 5'd5,  1'b0, 10'h260, 1'b1};

        model_reset();
        mux_data = $urandom();

        #12;
        chk("rst_ready", 32'(cfg_ready_o), 32'd0);
        chk("rst_done", 32'(cfg_done_o), 32'd0);
        chk("rst_err", 32'(cfg_err_o), 32'd0);
        chk("rst_sel", 32'(sel_out_o), 32'd0);
        chk("rst_cfg_out", 32'(cfg_out_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Valid asserted while idle must be ignored.
        cfg_valid_i = 1'b1;
        cfg_in_i    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_ready", 32'(cfg_ready_o), 32'd0);
            chk("idle_cfg_out", 32'(cfg_out_o), 32'd0);
        end
        cfg_valid_i = 1'b0;
        chk("idle_sel", 32'(sel_out_o), 32'd0);

        for (int v = 0; v < 7; v++) begin
            pulse_start();
            send_bits({vecs[v].f1, vecs[v].f0}, TOT, vecs[v].bub);
            finish_load(vecs[v].exp_sel, vecs[v].exp_err);
            if (v == 0) begin
                mux_data = $urandom();
                #1;
                chk("muxn_out0", 32'(mux_y[0]), 32'(mux_data[3]));
                chk("muxn_out1", 32'(mux_y[1]), 32'(mux_data[17]));
            end
        end

        // Restart after six beats: only the fresh ten beats reach sel_out.
        pulse_start();
        send_bits(10'($urandom()), 6, 1'b0);
        pulse_start();
        send_bits({5'd11, 5'd7}, TOT, 1'b1);
        finish_load({5'd11, 5'd7}, 1'b0);

        for (int r = 0; r < 30; r++) begin
            f0    = SW'($urandom_range(0, 31));
            f1    = SW'($urandom_range(0, 31));
            w     = {f1, f0};
            legal = (int'(f0) < IW) && (int'(f1) < IW);
            pulse_start();
            send_bits(w, TOT, r[0]);
            finish_load(legal ? w : sel_m, !legal);
        end

        // Asynchronous reset in the middle of a load discards everything.
        pulse_start();
        send_bits({5'd2, 5'd9}, 4, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(sel_out_o), 32'd0);
        chk("midrst_ready", 32'(cfg_ready_o), 32'd0);
        chk("midrst_err", 32'(cfg_err_o), 32'd0);
        chk("midrst_done", 32'(cfg_done_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pulse_start();
        send_bits({5'd1, 5'd18}, TOT, 1'b1);
        finish_load({5'd1, 5'd18}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
